// File: rtl/dsp_pll_supervisor.sv
// PLL reset sequencer and health monitor: lock wait with timeout/retry, then DSP clock frequency check.
// Frequency check present only when DSP_PLL_FREQ_CHECK_EN is defined; otherwise SETTLE goes straight to RUN.
module dsp_pll_supervisor #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 270000,
  parameter int SETTLE_CYCLES  = 2700,
  parameter int GATE_CYCLES    = 27000,
  parameter int CNT_MIN        = 94,
  parameter int CNT_MAX        = 97,
  parameter int MAX_RETRY      = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       dsp_tog,
  output logic       pll_reset,
  output logic       dsp_reset,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [7:0] meas_cnt
);

  typedef enum logic [2:0] {
    S_PLL_RST, S_WAIT_LOCK, S_SETTLE, S_MEASURE, S_RUN, S_FAULT
  } state_t;

  state_t      r_state;
  state_t      w_nxt;
  logic [18:0] r_cnt;
  logic [1:0]  r_lock_sync;
  logic        w_lock;
  logic        w_cnt_clr;
  logic        w_fail;
  logic        w_win_end;
  logic        w_in_range;
  logic [3:0]  w_retry_inc;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  assign w_lock = r_lock_sync[1];

`ifdef DSP_PLL_FREQ_CHECK_EN
  localparam state_t AFTER_SETTLE = S_MEASURE;

  logic [2:0] r_tog_sync;
  logic [7:0] r_edge_cnt;
  logic [7:0] r_meas;
  logic       w_edge;
  logic       w_gating;
  logic [7:0] w_win_cnt;

  function automatic logic [7:0] sat_add8(input logic [7:0] v, input logic e);
    return (v == 8'hFF) ? v : v + {7'd0, e};
  endfunction

  assign w_edge     = r_tog_sync[2] ^ r_tog_sync[1];
  assign w_gating   = (r_state == S_MEASURE) || (r_state == S_RUN);
  assign w_win_end  = w_gating && (r_cnt == 19'(GATE_CYCLES - 1));
  // An edge on the closing cycle belongs to the closing window.
  assign w_win_cnt  = sat_add8(r_edge_cnt, w_edge);
  assign w_in_range = (w_win_cnt >= 8'(CNT_MIN)) && (w_win_cnt <= 8'(CNT_MAX));
  assign meas_cnt   = r_meas;

  always_ff @(posedge clk) begin
    r_tog_sync <= {r_tog_sync[1:0], dsp_tog};
    if (!w_gating || w_win_end) r_edge_cnt <= 8'd0;
    else                        r_edge_cnt <= w_win_cnt;
    if (reset)          r_meas <= 8'd0;
    else if (w_win_end) r_meas <= w_win_cnt;
  end
`else
  localparam state_t AFTER_SETTLE = S_RUN;

  logic w_unused;
  assign w_unused   = ^{dsp_tog, 32'(GATE_CYCLES), 32'(CNT_MIN), 32'(CNT_MAX)};
  assign w_win_end  = 1'b0;
  assign w_in_range = 1'b1;
  assign meas_cnt   = 8'd0;
`endif

  always_comb begin
    w_nxt     = r_state;
    w_cnt_clr = 1'b0;
    w_fail    = 1'b0;
    case (r_state)
      S_PLL_RST:
        if (r_cnt == 19'(PLL_RST_CYCLES - 1)) w_nxt = S_WAIT_LOCK;
      S_WAIT_LOCK:
        if (w_lock) w_nxt = S_SETTLE;
        else if (r_cnt == 19'(LOCK_TIMEOUT - 1)) w_fail = 1'b1;
      S_SETTLE:
        if (!w_lock) w_cnt_clr = 1'b1;
        else if (r_cnt == 19'(SETTLE_CYCLES - 1)) w_nxt = AFTER_SETTLE;
      S_MEASURE:
        if (!w_lock) w_fail = 1'b1;
        else if (w_win_end) begin
          if (w_in_range) w_nxt = S_RUN;
          else            w_fail = 1'b1;
        end
      S_RUN:
        if (!w_lock) w_fail = 1'b1;
        else if (w_win_end) begin
          if (w_in_range) w_cnt_clr = 1'b1;
          else            w_fail = 1'b1;
        end
      S_FAULT: ;
      default: w_nxt = S_PLL_RST;
    endcase
    w_retry_inc = sat_inc4(retry_cnt);
    if (w_fail) w_nxt = (w_retry_inc >= 4'(MAX_RETRY)) ? S_FAULT : S_PLL_RST;
  end

  // Outputs are decoded from the next state so they move on the same edge as the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_PLL_RST;
      r_cnt       <= 19'd0;
      r_lock_sync <= 2'b00;
      pll_reset   <= 1'b1;
      dsp_reset   <= 1'b1;
      ready       <= 1'b0;
      fault       <= 1'b0;
      retry_cnt   <= 4'd0;
    end else begin
      r_lock_sync <= {r_lock_sync[0], pll_lock};
      r_state     <= w_nxt;
      if ((w_nxt != r_state) || w_cnt_clr) r_cnt <= 19'd0;
      else if (r_state != S_FAULT)         r_cnt <= r_cnt + 19'd1;
      if (w_fail)                                   retry_cnt <= w_retry_inc;
      else if ((w_nxt == S_RUN) && (r_state != S_RUN)) retry_cnt <= 4'd0;
      pll_reset <= (w_nxt == S_PLL_RST) || (w_nxt == S_FAULT);
      dsp_reset <= (w_nxt != S_RUN);
      ready     <= (w_nxt == S_RUN);
      fault     <= (w_nxt == S_FAULT);
    end
  end

endmodule
